wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback stage (ResultW path);
  - the multi-cycle M-extension unit (DIV/DIVU/REM/REMU).
- Buffers M-unit results in a small FIFO and drains them into idle write-port cycles.
- Forces a one-cycle writeback stall when a buffered result starves.
- Reports RAW/WAW hazards against pending buffered destinations to the hazard unit.

Parameters:
- DEPTH, 4: FIFO entries for M-unit results; power of two, 2..8.
- STARVE_LIMIT, 8: cycles the FIFO head may wait before a forced drain; 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteW  in  1  pipeline W-stage write enable.
- RDW  in  5  pipeline W-stage destination.
- ResultW  in  32  pipeline W-stage write data.
- md_valid  in  1  M-unit result valid.
- md_rd  in  5  M-unit destination.
- md_result  in  32  M-unit result.
- md_ready  out  1  FIFO can accept; high when count < DEPTH.
- q_rs1  in  5  hazard query, source 1 of the D-stage instruction.
- q_rs2  in  5  hazard query, source 2.
- q_rd  in  5  hazard query, destination (WAW check).
- md_hazard  out  1  any query register matches a pending destination.
- wb_stall  out  1  W-stage must hold this cycle; its write is not performed.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wd  out  32  register-file write data.

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO empty, starvation counter 0, wb_stall 0.
  - Registered outputs return to 0 the following cycle.
  - Reset mid-operation discards all buffered results; the M unit is reset by the same rst.
- Write-port outputs are combinational from the current state and inputs (0-cycle latency):
  - rf_we/rf_rd/rf_wd are driven by the pipeline when it is granted, otherwise by the FIFO head.
  - rf_we is 0 when neither source is granted.
- Pipeline write is "active" when RegWriteW=1 and RDW!=0.
- Grant priority, highest first:
  1. wb_stall=1: FIFO head granted; pipeline write suppressed. The hazard unit freezes the W-stage register, so the same write is re-presented next cycle.
  2. Pipeline active: pipeline granted.
  3. FIFO non-empty: head granted; pop at clk edge.
- FIFO head with rd=0: popped whenever granted, with rf_we=0 (x0 writes discarded).
- Push: md_valid & md_ready → enqueue {md_rd, md_result} at the clk edge.
  - md_valid while full is a protocol violation; the entry is dropped and the FIFO stays unchanged.
  - Simultaneous push and pop when full is not accepted: md_ready already 0.
  - Simultaneous push and pop when empty is legal; the pushed entry becomes the head next cycle. No same-cycle bypass.
- Pointers wrap modulo DEPTH; count is held separately, 0..DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop, and when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, wb_stall is registered high for exactly one cycle and the counter clears.
- wb_stall state machine, states IDLE and FORCE:
  - IDLE → FORCE on reaching the limit.
  - FORCE → IDLE unconditionally after one cycle.
  - In FORCE the head always pops.
- md_hazard:
  - Asserted if any nonzero q_rs1/q_rs2/q_rd equals the rd of any valid FIFO entry.
  - Also asserted if it equals md_rd while md_valid=1.
  - x0 never matches.
  - The check is combinational.
- Ordering:
  - Same-rd WAW between the pipeline and FIFO is excluded by the hazard unit via md_hazard.
  - The arbiter does not reorder FIFO entries.

Optional Feature:
- WB_ARB_STATS_EN defined:
  - Adds outputs stat_forced (32-bit count of FORCE cycles) and stat_drained (32-bit count of FIFO pops with rf_we=1).
  - Both counters clear on rst and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then md_valid with md_rd=5, md_result=0x0000000A, RegWriteW=0:
  - entry pushed;
  - next cycle rf_we=1, rf_rd=5, rf_wd=0x0000000A;
  - FIFO empty after.
- Pipeline RegWriteW=1, RDW=3, ResultW=0x11 held every cycle; one M result pushed for rd=7 (STARVE_LIMIT=8):
  - pipeline owns the port for 8 cycles;
  - next cycle wb_stall=1, rf_rd=7;
  - following cycle rf_rd=3 again, wb_stall=0.
- Push 4 results (DEPTH=4) while the pipeline writes continuously:
  - md_ready=0 after the 4th push;
  - a 5th md_valid does not change count;
  - with the pipeline idle, drains in order over 4 cycles, then md_ready=1.
- Entry pending for rd=9:
  - q_rs1=9 → md_hazard=1;
  - q_rd=9 → md_hazard=1;
  - q_rs2=0 with md_rd=0 → md_hazard=0.
- M result with md_rd=0 → popped with rf_we=0; register file unchanged.
- Assert rst with 3 entries buffered → next cycle md_ready=1, rf_we=0, md_hazard=0 for all queries.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the W stage and buffered M-unit results.
// Optional statistics counters are compiled in when WB_ARB_STATS_EN is defined.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  output logic        md_ready,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  input  logic [4:0]  q_rd,
  output logic        md_hazard,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_forced,
  output logic [31:0] stat_drained
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, FORCE} state_t;

  state_t         state, state_nx;
  logic [4:0]     mem_rd [DEPTH];
  logic [31:0]    mem_wd [DEPTH];
  logic [AW-1:0]  rptr, wptr;
  logic [CW-1:0]  count;
  logic [7:0]     starve_cnt, starve_nx;
  logic           fifo_empty, pipe_active, push, pop;
  logic [4:0]     head_rd;
  logic [31:0]    head_wd;
  logic [AW-1:0]  off_v [DEPTH];
  logic [DEPTH-1:0] ent_v;

  assign fifo_empty  = (count == '0);
  assign md_ready    = (count < CW'(DEPTH));
  assign pipe_active = RegWriteW && (RDW != 5'd0);
  assign head_rd     = mem_rd[rptr];
  assign head_wd     = mem_wd[rptr];
  assign push        = md_valid && md_ready;
  assign wb_stall    = (state == FORCE);

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    pop       = 1'b0;
    rf_we     = 1'b0;
    rf_rd     = RDW;
    rf_wd     = ResultW;
    if (wb_stall || !pipe_active) begin
      if (!fifo_empty) begin
        pop   = 1'b1;
        rf_we = (head_rd != 5'd0);
        rf_rd = head_rd;
        rf_wd = head_wd;
      end
    end else begin
      rf_we = 1'b1;
    end
    case (state)
      IDLE: begin
        if (!fifo_empty && !pop) begin
          // Limit counts the stalled cycles themselves, so compare the incremented value.
          if ({1'b0, starve_cnt} + 9'd1 == 9'(STARVE_LIMIT)) begin
            state_nx  = FORCE;
            starve_nx = '0;
          end else begin
            starve_nx = starve_cnt + 8'd1;
          end
        end else begin
          starve_nx = '0;
        end
      end
      FORCE: begin
        state_nx  = IDLE;
        starve_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    md_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v[i] = AW'(i) - rptr;
      ent_v[i] = ({1'b0, off_v[i]} < count);
      if (ent_v[i] && mem_rd[i] != 5'd0 &&
          (mem_rd[i] == q_rs1 || mem_rd[i] == q_rs2 || mem_rd[i] == q_rd))
        md_hazard = 1'b1;
    end
    if (md_valid && md_rd != 5'd0 &&
        (md_rd == q_rs1 || md_rd == q_rs2 || md_rd == q_rd))
      md_hazard = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_rd[wptr] <= md_rd;
      mem_wd[wptr] <= md_result;
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_forced  <= '0;
      stat_drained <= '0;
    end else begin
      if (wb_stall && stat_forced != 32'hFFFF_FFFF)
        stat_forced <= stat_forced + 32'd1;
      if (pop && rf_we && stat_drained != 32'hFFFF_FFFF)
        stat_drained <= stat_drained + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts each cycle's
// write-port, stall, ready and hazard outputs; a separate monitor pops and compares them.
module tb_wb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        md_hazard, wb_stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_forced, stat_drained;
`endif

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_ready(md_ready),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .md_hazard(md_hazard),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
`ifdef WB_ARB_STATS_EN
    , .stat_forced(stat_forced), .stat_drained(stat_drained)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        stall;
    logic        ready;
    logic        haz;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   age = 0;
  bit   frc = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  function automatic bit qhit(input logic [4:0] r);
    return (r != 5'd0) && (r == q_rs1 || r == q_rs2 || r == q_rd);
  endfunction

  // Reference model: one call per cycle, after inputs are applied.
  task automatic model_step();
    exp_t e;
    bit   head_g, nonempty, ready;
    nonempty = (mq.size() > 0);
    ready    = (mq.size() < DEPTH);
    e.we = 1'b0; e.rd = 5'd0; e.wd = 32'd0;
    e.stall = frc; e.ready = ready; e.haz = 1'b0;
    head_g = 1'b0;
    if (frc) head_g = nonempty;
    else if (RegWriteW && RDW != 5'd0) begin
      e.we = 1'b1; e.rd = RDW; e.wd = ResultW;
    end else head_g = nonempty;
    if (head_g) begin
      e.we = (mq[0].rd != 5'd0); e.rd = mq[0].rd; e.wd = mq[0].wd;
    end
    foreach (mq[i]) if (qhit(mq[i].rd)) e.haz = 1'b1;
    if (md_valid && qhit(md_rd)) e.haz = 1'b1;
    exp_q.push_back(e);

    if (rst) begin
      mq.delete(); age = 0; frc = 1'b0;
    end else begin
      if (head_g) void'(mq.pop_front());
      if (md_valid && ready) mq.push_back('{rd: md_rd, wd: md_result});
      if (frc || head_g || !nonempty) begin
        frc = 1'b0; age = 0;
      end else begin
        age++;
        if (age == LIMIT) begin frc = 1'b1; age = 0; end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic we, input logic [4:0] rdw, input logic [31:0] res,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    @(negedge clk);
    rst = r; RegWriteW = we; RDW = rdw; ResultW = res;
    md_valid = mv; md_rd = mrd; md_result = mres;
    q_rs1 = s1; q_rs2 = s2; q_rd = d;
    #1;
    model_step();
  endtask

  // Monitor: compares every predicted cycle after the stimulus side has pushed it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        if (e.we) begin
          chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
          chk("rf_wd", rf_wd, e.wd);
        end
        chk("wb_stall", {31'd0, wb_stall}, {31'd0, e.stall});
        chk("md_ready", {31'd0, md_ready}, {31'd0, e.ready});
        chk("md_hazard", {31'd0, md_hazard}, {31'd0, e.haz});
      end
    end
  end

  initial begin
    int stall_at;
    rst = 1'b1; RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    md_valid = 1'b0; md_rd = '0; md_result = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    repeat (2) @(posedge clk);

    // single M result drains into an idle port
    cyc(0, 0, 0, 0, 1, 5'd5, 32'h0000_000A, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // starvation under continuous pipeline writes
    stall_at = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 5'd3, 32'h11, (i == 0), 5'd7, 32'h77, 0, 0, 0);
      if (wb_stall === 1'b1 && stall_at < 0) stall_at = i;
    end
    chk("starve_cycle", stall_at, 9);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // fill to DEPTH, one dropped push, then in-order drain
    for (int i = 0; i < 5; i++) cyc(0, 1, 5'd3, 32'h11, 1, 5'(10 + i), 32'(100 + i), 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // hazard queries against a pending rd=9
    cyc(0, 1, 5'd2, 32'h22, 1, 5'd9, 32'h99, 0, 0, 0);
    cyc(0, 1, 5'd2, 32'h22, 0, 0, 0, 5'd9, 0, 0);
    cyc(0, 1, 5'd2, 32'h22, 0, 0, 0, 0, 0, 5'd9);
    cyc(0, 1, 5'd2, 32'h22, 1, 5'd0, 32'h5, 0, 5'd0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 result is popped silently
    cyc(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with three buffered entries
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'd4, 32'h44, 1, 5'(20 + i), 32'(200 + i), 0, 0, 0);
    cyc(1, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21, 5'd22);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'd22, 0, 5'd20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, we, mv;
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 99) < 60);
      if (mq.size() < DEPTH) mv = ($urandom_range(0, 99) < 40);
      else mv = ($urandom_range(0, 99) < 5);
      cyc(r, we, 5'($urandom_range(0, 31)), $urandom, mv, 5'($urandom_range(0, 15)), $urandom,
          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    #3;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
